// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_sequencer
// Description : Iterative 32-step unsigned multiply (MULTU) / divide (DIVU)
//               controller. It borrows the shared EX-stage ALU for the
//               add/subtract of each step. Shifting, carry/borrow detection
//               and step counting are done locally. Results land in HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'd0,
  parameter logic [4:0] ALU_SUB = 5'd1,
  parameter int         STEPS   = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic [4:0]  AluCtl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [4:0] C_LAST_STEP = 5'(STEPS - 1);

  // acc_hi/acc_lo hold {P_hi, P_lo} while multiplying and {R, Q} while
  // dividing; opnd holds the multiplicand M or the divisor D.
  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        w_carry;
  logic        w_take;
  logic [31:0] w_shifted;
  logic [31:0] w_mul_hi, w_mul_lo;
  logic [31:0] w_div_hi, w_div_lo;

  // Per-step datapath: next accumulator values for both algorithms
  always_comb begin
    w_carry   = (AluResult < acc_hi_q);
    w_shifted = {acc_hi_q[30:0], acc_lo_q[31]};
    // A set shifted-out bit means the true remainder exceeds 32 bits,
    // so it is always at least D.
    w_take    = acc_hi_q[31] | (w_shifted >= opnd_q);
    if (acc_lo_q[0]) begin
      {w_mul_hi, w_mul_lo} = {w_carry, AluResult, acc_lo_q[31:1]};
    end else begin
      {w_mul_hi, w_mul_lo} = {1'b0, acc_hi_q, acc_lo_q[31:1]};
    end
    w_div_hi = w_take ? AluResult : w_shifted;
    w_div_lo = {acc_lo_q[30:0], w_take};
  end

  // Next-state, register updates and ALU operand selection
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    AluCtl   = ALU_ADD;
    AluA     = 32'd0;
    AluB     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          dbz_d   = 1'b0;
          count_d = 5'd0;
          if (!Op) begin
            state_d  = S_MUL;
            acc_hi_d = 32'd0;
            acc_lo_d = OpB;
            opnd_d   = OpA;
          end else if (OpB != 32'd0) begin
            state_d  = S_DIV;
            acc_hi_d = 32'd0;
            acc_lo_d = OpA;
            opnd_d   = OpB;
          end else begin
            state_d = S_FIN;
            hi_d    = OpA;
            lo_d    = 32'hFFFF_FFFF;
            dbz_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        AluCtl   = ALU_ADD;
        AluA     = acc_hi_q;
        AluB     = opnd_q;
        acc_hi_d = w_mul_hi;
        acc_lo_d = w_mul_lo;
        count_d  = count_q + 5'd1;
        if (count_q == C_LAST_STEP) begin
          state_d = S_FIN;
          hi_d    = w_mul_hi;
          lo_d    = w_mul_lo;
          count_d = 5'd0;
        end
      end
      S_DIV: begin
        AluCtl   = ALU_SUB;
        AluA     = w_shifted;
        AluB     = opnd_q;
        acc_hi_d = w_div_hi;
        acc_lo_d = w_div_lo;
        count_d  = count_q + 5'd1;
        if (count_q == C_LAST_STEP) begin
          state_d = S_FIN;
          hi_d    = w_div_hi;
          lo_d    = w_div_lo;
          count_d = 5'd0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign Done      = (state_q == S_FIN);
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

  // The shared ALU must never see unknown operands while the pipeline owns it
  a_idle_known: assert property (@(posedge Clk) disable iff (!Rst)
    (state_q == S_IDLE) |-> !$isunknown({AluCtl, AluA, AluB}));

  // The zero flag must agree with the result the steps consume
  a_zero_consistent: assert property (@(posedge Clk) disable iff (!Rst)
    Busy |-> (AluZero == (AluResult == 32'd0)));

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_sequencer
// Description : Directed self-checking bench for alu_muldiv_sequencer with a
//               behavioural model of the shared add/subtract ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_sequencer;

  localparam logic [4:0] C_ADD = 5'd0;
  localparam logic [4:0] C_SUB = 5'd1;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Op;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [4:0]  AluCtl;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [31:0] AluResult;
  logic        AluZero;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv_sequencer #(
    .ALU_ADD(C_ADD),
    .ALU_SUB(C_SUB),
    .STEPS  (32)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .OpA      (OpA),
    .OpB      (OpB),
    .AluCtl   (AluCtl),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluResult(AluResult),
    .AluZero  (AluZero),
    .Busy     (Busy),
    .Done     (Done),
    .DivByZero(DivByZero),
    .Hi       (Hi),
    .Lo       (Lo)
  );

  // Shared ALU model: add or subtract, combinational
  always_comb begin
    AluResult = 32'd0;
    if (AluCtl == C_ADD) AluResult = AluA + AluB;
    else if (AluCtl == C_SUB) AluResult = AluA - AluB;
    AluZero = (AluResult == 32'd0);
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one operation and check cycle timing plus the final result.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int bad;
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    step();
    Start = 1'b0; OpA = 32'hDEAD_BEEF; OpB = 32'hDEAD_BEEF;
    if (!exp_dbz) begin
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (!(Busy === 1'b1 && Done === 1'b0 && AluCtl === (op ? C_SUB : C_ADD))) bad++;
        step();
      end
      chk({tag, "_step_cycles_bad"}, 32'(bad), 32'd0);
    end
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    chk({tag, "_busy_fin"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_hi"}, Hi, exp_hi);
    chk({tag, "_lo"}, Lo, exp_lo);
    chk({tag, "_dbz"}, {31'd0, DivByZero}, {31'd0, exp_dbz});
    step();
    chk({tag, "_done_drop"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    int dones;
    Rst = 1'b0; Start = 1'b0; Op = 1'b0; OpA = 32'd0; OpB = 32'd0;
    step();
    step();
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    chk("rst_aluctl", {27'd0, AluCtl}, {27'd0, C_ADD});
    chk("rst_alua", AluA, 32'd0);
    Rst = 1'b1;
    step();
    chk("idle_busy", {31'd0, Busy}, 32'd0);

    run_op("mul_65x33", 1'b0, 32'd65, 32'd33, 32'd0, 32'h0000_0861, 1'b0);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_64_32", 1'b1, 32'd64, 32'd32, 32'd0, 32'd2, 1'b0);
    run_op("div_max_3", 1'b1, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h5555_5555, 1'b0);
    run_op("div_msb", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_op("div_by0", 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("mul_6x10", 1'b0, 32'd6, 32'd10, 32'd0, 32'd60, 1'b0);

    // Start pulsed mid-multiply must be ignored and yield a single Done
    Start = 1'b1; Op = 1'b0; OpA = 32'd7; OpB = 32'd9;
    step();
    Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin
        Start = 1'b1; Op = 1'b1; OpA = 32'd5; OpB = 32'd0;
      end else begin
        Start = 1'b0;
      end
      if (Done === 1'b1) dones++;
      step();
    end
    chk("ign_done_count", 32'(dones), 32'd1);
    chk("ign_lo", Lo, 32'd63);
    chk("ign_hi", Hi, 32'd0);
    chk("ign_dbz", {31'd0, DivByZero}, 32'd0);

    // Asynchronous reset during a divide
    Start = 1'b1; Op = 1'b1; OpA = 32'd1000; OpB = 32'd7;
    step();
    Start = 1'b0;
    repeat (15) step();
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_done", {31'd0, Done}, 32'd0);
    chk("arst_hi", Hi, 32'd0);
    chk("arst_lo", Lo, 32'd0);
    chk("arst_alub", AluB, 32'd0);
    step();
    Rst = 1'b1;
    step();
    run_op("div_1000_7", 1'b1, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
